controlador_reloj_digital: RTL and testbench

- Hard-wired controller for an external RTC chip with a multiplexed 8-bit address/data bus.
- After reset it initializes the RTC with two register writes. It then reads the time/date registers (seconds to year) in an endless loop.
- Each completed transaction is reported on a PicoBlaze-style port_id/out_port pair plus a done flag, for downstream display logic and debug.

---
 rtl/controlador_reloj_digital_pkg.sv | 72 +++++++
 rtl/controlador_reloj_digital_bus_cycle.sv | 153 +++++++++++++++
 rtl/controlador_reloj_digital.sv | 89 ++++++++
 tb/tb_controlador_reloj_digital.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/controlador_reloj_digital_pkg.sv
// Shared constants, state/index enums and transaction-table helpers for the
// RTC bus controller.
package controlador_reloj_digital_pkg;

  localparam logic [7:0] ADDR_CTRL = 8'h02;
  localparam logic [7:0] ADDR_SEG  = 8'h21;
  localparam logic [7:0] ADDR_MIN  = 8'h22;
  localparam logic [7:0] ADDR_HORA = 8'h23;
  localparam logic [7:0] ADDR_DIA  = 8'h24;
  localparam logic [7:0] ADDR_MES  = 8'h25;
  localparam logic [7:0] ADDR_ANIO = 8'h26;

  localparam logic [7:0] INIT_SET = 8'h10;
  localparam logic [7:0] INIT_CLR = 8'h00;

  typedef enum logic [2:0] {
    BUS_IDLE,
    BUS_A_SETUP,
    BUS_A_STROBE,
    BUS_A_HOLD,
    BUS_D_SETUP,
    BUS_D_STROBE,
    BUS_D_HOLD,
    BUS_DONE
  } bus_state_e;

  typedef enum logic [2:0] {
    TR_INIT_SET,
    TR_INIT_CLR,
    TR_SEG,
    TR_MIN,
    TR_HORA,
    TR_DIA,
    TR_MES,
    TR_ANIO
  } tr_idx_e;

  function automatic logic [7:0] tr_addr(input tr_idx_e tr);
    case (tr)
      TR_INIT_SET, TR_INIT_CLR: tr_addr = ADDR_CTRL;
      TR_SEG:                   tr_addr = ADDR_SEG;
      TR_MIN:                   tr_addr = ADDR_MIN;
      TR_HORA:                  tr_addr = ADDR_HORA;
      TR_DIA:                   tr_addr = ADDR_DIA;
      TR_MES:                   tr_addr = ADDR_MES;
      default:                  tr_addr = ADDR_ANIO;
    endcase
  endfunction

  function automatic logic tr_is_read(input tr_idx_e tr);
    tr_is_read = !((tr == TR_INIT_SET) || (tr == TR_INIT_CLR));
  endfunction

  function automatic logic [7:0] tr_wdata(input tr_idx_e tr);
    tr_wdata = (tr == TR_INIT_SET) ? INIT_SET : INIT_CLR;
  endfunction

  // Init runs once; after the year read the loop goes back to seconds.
  function automatic tr_idx_e tr_next(input tr_idx_e tr);
    case (tr)
      TR_INIT_SET: tr_next = TR_INIT_CLR;
      TR_INIT_CLR: tr_next = TR_SEG;
      TR_SEG:      tr_next = TR_MIN;
      TR_MIN:      tr_next = TR_HORA;
      TR_HORA:     tr_next = TR_DIA;
      TR_DIA:      tr_next = TR_MES;
      TR_MES:      tr_next = TR_ANIO;
      default:     tr_next = TR_SEG;
    endcase
  endfunction

endpackage

// File: rtl/controlador_reloj_digital_bus_cycle.sv
// Single RTC bus transaction engine: address phase then data phase on the
// multiplexed bus, each split into setup/strobe/hold of PHASE_CYC cycles.
//
// state        | meaning
// BUS_IDLE     | bus parked, waiting for start
// BUS_A_SETUP  | address on dato, cs low
// BUS_A_STROBE | address on dato, wr low (address latch strobe)
// BUS_A_HOLD   | address on dato, strobe released
// BUS_D_SETUP  | data phase, write data driven (writes only)
// BUS_D_STROBE | wr or rd low; read data captured on the final edge
// BUS_D_HOLD   | strobe released, write data still driven
// BUS_DONE     | one bus-idle cycle; may chain straight into the next start
module rtc_bus_cycle #(
  parameter int unsigned PHASE_CYC = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rw,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       done,
  output logic       reg_a_d,
  output logic       reg_cs,
  output logic       reg_rd,
  output logic       reg_wr,
  inout  wire  [7:0] dato
);
  import controlador_reloj_digital_pkg::*;

  localparam logic [7:0] PHASE_LOAD = 8'(PHASE_CYC - 1);

  bus_state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       rw_q, rw_d;
  logic [7:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic       a_d_q, a_d_d, cs_q, cs_d, rd_q, rd_d, wr_q, wr_d;
  logic       drive_q, drive_d;
  logic [7:0] bus_out_q, bus_out_d;
  logic       phase_end;

  // Next state: down-counter per phase, advance on terminal count.
  always_comb begin
    state_d   = state_q;
    cnt_d     = (cnt_q != 8'd0) ? (cnt_q - 8'd1) : cnt_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    done      = 1'b0;
    phase_end = (cnt_q == 8'd0);
    case (state_q)
      BUS_IDLE, BUS_DONE: begin
        if (start) begin
          state_d = BUS_A_SETUP;
          cnt_d   = PHASE_LOAD;
          rw_d    = rw;
          addr_d  = addr;
          wdata_d = wdata;
        end else begin
          state_d = BUS_IDLE;
        end
      end
      BUS_A_SETUP:  if (phase_end) begin state_d = BUS_A_STROBE; cnt_d = PHASE_LOAD; end
      BUS_A_STROBE: if (phase_end) begin state_d = BUS_A_HOLD;   cnt_d = PHASE_LOAD; end
      BUS_A_HOLD:   if (phase_end) begin state_d = BUS_D_SETUP;  cnt_d = PHASE_LOAD; end
      BUS_D_SETUP:  if (phase_end) begin state_d = BUS_D_STROBE; cnt_d = PHASE_LOAD; end
      BUS_D_STROBE: begin
        if (phase_end) begin
          state_d = BUS_D_HOLD;
          cnt_d   = PHASE_LOAD;
          if (rw_q) rdata_d = dato;
        end
      end
      BUS_D_HOLD: begin
        if (phase_end) begin
          state_d = BUS_DONE;
          done    = 1'b1;
        end
      end
      default: state_d = BUS_IDLE;
    endcase
  end

  // Bus pins decoded from the upcoming state so they change with the state register.
  always_comb begin
    a_d_d     = 1'b1;
    cs_d      = 1'b1;
    rd_d      = 1'b1;
    wr_d      = 1'b1;
    drive_d   = 1'b0;
    bus_out_d = bus_out_q;
    case (state_d)
      BUS_A_SETUP, BUS_A_STROBE, BUS_A_HOLD: begin
        a_d_d     = 1'b0;
        cs_d      = 1'b0;
        wr_d      = (state_d != BUS_A_STROBE);
        drive_d   = 1'b1;
        bus_out_d = addr_d;
      end
      BUS_D_SETUP, BUS_D_STROBE, BUS_D_HOLD: begin
        cs_d      = 1'b0;
        drive_d   = !rw_d;
        bus_out_d = wdata_d;
        if (state_d == BUS_D_STROBE) begin
          rd_d = !rw_d;
          wr_d = rw_d;
        end
      end
      default: ;
    endcase
  end

  // State, counter, latched request and registered bus pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= BUS_IDLE;
      cnt_q     <= 8'd0;
      rw_q      <= 1'b0;
      addr_q    <= 8'h00;
      wdata_q   <= 8'h00;
      rdata_q   <= 8'h00;
      a_d_q     <= 1'b1;
      cs_q      <= 1'b1;
      rd_q      <= 1'b1;
      wr_q      <= 1'b1;
      drive_q   <= 1'b0;
      bus_out_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      a_d_q     <= a_d_d;
      cs_q      <= cs_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      drive_q   <= drive_d;
      bus_out_q <= bus_out_d;
    end
  end

  assign rdata   = rdata_q;
  assign reg_a_d = a_d_q;
  assign reg_cs  = cs_q;
  assign reg_rd  = rd_q;
  assign reg_wr  = wr_q;
  assign dato    = drive_q ? bus_out_q : 8'hzz;

endmodule

// File: rtl/controlador_reloj_digital.sv
// RTC controller top: walks the fixed transaction list (two init writes,
// then an endless time/date read loop with an idle gap between rounds) and
// reports each completed transaction on port_id/out_port with a done flag.
module controlador_reloj_digital #(
  parameter int unsigned PHASE_CYC = 10,
  parameter int unsigned ROUND_GAP = 100
) (
  input  logic       clk,
  input  logic       reset,
  output logic       reg_a_d,
  output logic       reg_cs,
  output logic       reg_rd,
  output logic       reg_wr,
  output logic [7:0] port_id,
  output logic [7:0] out_port,
  output logic [7:0] fin_lectura_escritura,
  inout  wire  [7:0] dato
);
  import controlador_reloj_digital_pkg::*;

  tr_idx_e     tr_q, tr_d;
  logic [15:0] gap_q, gap_d;
  logic [7:0]  port_id_q, port_id_d, out_port_q, out_port_d;
  logic        fin_q, fin_d;
  logic        start, cur_rw, bus_done;
  logic [7:0]  cur_addr, cur_wdata, bus_rdata;

  assign cur_addr  = tr_addr(tr_q);
  assign cur_rw    = tr_is_read(tr_q);
  assign cur_wdata = tr_wdata(tr_q);
  // The engine only samples start in IDLE/DONE, so holding it high chains transactions.
  assign start     = (gap_q == 16'd0);

  rtc_bus_cycle #(
    .PHASE_CYC(PHASE_CYC)
  ) u_bus (
    .clk    (clk),
    .rst_n  (reset),
    .start  (start),
    .rw     (cur_rw),
    .addr   (cur_addr),
    .wdata  (cur_wdata),
    .rdata  (bus_rdata),
    .done   (bus_done),
    .reg_a_d(reg_a_d),
    .reg_cs (reg_cs),
    .reg_rd (reg_rd),
    .reg_wr (reg_wr),
    .dato   (dato)
  );

  // Sequencer step, round gap down-counter and result capture for the DONE cycle.
  always_comb begin
    tr_d       = tr_q;
    gap_d      = (gap_q != 16'd0) ? (gap_q - 16'd1) : gap_q;
    port_id_d  = port_id_q;
    out_port_d = out_port_q;
    fin_d      = 1'b0;
    if (bus_done) begin
      port_id_d  = cur_addr;
      out_port_d = cur_rw ? bus_rdata : cur_wdata;
      fin_d      = 1'b1;
      tr_d       = tr_next(tr_q);
      if (tr_q == TR_ANIO) gap_d = 16'(ROUND_GAP);
    end
  end

  // Sequencer and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tr_q       <= TR_INIT_SET;
      gap_q      <= 16'd0;
      port_id_q  <= 8'h00;
      out_port_q <= 8'h00;
      fin_q      <= 1'b0;
    end else begin
      tr_q       <= tr_d;
      gap_q      <= gap_d;
      port_id_q  <= port_id_d;
      out_port_q <= out_port_d;
      fin_q      <= fin_d;
    end
  end

  assign port_id               = port_id_q;
  assign out_port              = out_port_q;
  assign fin_lectura_escritura = {7'b0, fin_q};

endmodule

// File: tb/tb_controlador_reloj_digital.sv
`timescale 1ns/1ps
module tb_controlador_reloj_digital;
  localparam int PHASE  = 10;
  localparam int GAP    = 100;
  localparam int TLEN   = 6 * PHASE + 1;
  localparam int ROUNDS = 6;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    logic       wr;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       reg_a_d, reg_cs, reg_rd, reg_wr;
  logic [7:0] port_id, out_port, fin;
  wire  [7:0] dato;

  logic       probe_en;
  logic [7:0] addr_lat;
  logic [7:0] rtc_mem [0:255];

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   popped = 0;
  int   a_low = 0, wr_a = 0, strobe_d = 0;
  exp_t exp_q[$];
  int   exp_cyc_all[$];
  exp_t e_mon;

  always #5 clk = ~clk;

  controlador_reloj_digital #(
    .PHASE_CYC(PHASE),
    .ROUND_GAP(GAP)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .reg_a_d              (reg_a_d),
    .reg_cs               (reg_cs),
    .reg_rd               (reg_rd),
    .reg_wr               (reg_wr),
    .port_id              (port_id),
    .out_port             (out_port),
    .fin_lectura_escritura(fin),
    .dato                 (dato)
  );

  // RTC chip model: answers reads from its register array; probe drives a marker in reset.
  assign dato = (!reg_rd) ? rtc_mem[addr_lat] : (probe_en ? 8'h5A : 8'hzz);

  always @(negedge clk)
    if (reset && !reg_a_d && !reg_wr) addr_lat <= dato;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference transaction list: what should complete, with what data, at which cycle.
  function automatic void build_expect();
    int   t;
    exp_t e;
    exp_q.delete();
    exp_cyc_all.delete();
    t = 0;
    for (int k = 0; k < 2; k++) begin
      t += TLEN;
      e.addr = 8'h02; e.data = (k == 0) ? 8'h10 : 8'h00; e.wr = 1'b1; e.cyc = t;
      exp_q.push_back(e);
      exp_cyc_all.push_back(t);
    end
    for (int r = 0; r < ROUNDS; r++) begin
      for (int i = 0; i < 6; i++) begin
        t += TLEN + ((r > 0 && i == 0) ? GAP : 0);
        e.addr = 8'(8'h21 + i); e.data = rtc_mem[8'(8'h21 + i)]; e.wr = 1'b0; e.cyc = t;
        exp_q.push_back(e);
        exp_cyc_all.push_back(t);
      end
    end
  endfunction

  task automatic count_check(input string name);
    int n;
    n = 0;
    foreach (exp_cyc_all[i]) if (exp_cyc_all[i] <= cyc) n++;
    chk(name, popped, n);
  endtask

  task automatic probe_check();
    probe_en = 1'b1;
    #1;
    chk("dato_released_in_reset", int'(dato), 8'h5A);
    probe_en = 1'b0;
  endtask

  // Monitor: protocol checks every cycle, pops the scoreboard on every done pulse.
  always @(negedge clk) begin
    if (!reset) begin
      cyc = 0; a_low = 0; wr_a = 0; strobe_d = 0;
      chk("rst_strobes", int'({reg_a_d, reg_cs, reg_rd, reg_wr}), 4'hF);
      chk("rst_fin", int'(fin), 0);
      chk("rst_port_id", int'(port_id), 0);
      chk("rst_out_port", int'(out_port), 0);
    end else begin
      cyc++;
      chk("fin_upper_bits", int'(fin[7:1]), 0);
      if (!reg_rd || !reg_wr) begin
        chk("rd_wr_exclusive", int'(reg_rd | reg_wr), 1);
        chk("cs_with_strobe", int'(reg_cs), 0);
      end
      if (!reg_a_d) a_low++;
      if (!reg_a_d && !reg_wr) wr_a++;
      if (reg_a_d && (!reg_wr || !reg_rd)) strobe_d++;
      if (!reg_cs && exp_q.size() > 0) begin
        if (!reg_a_d) chk("addr_on_bus", int'(dato), int'(exp_q[0].addr));
        else if (exp_q[0].wr) chk("wdata_on_bus", int'(dato), int'(exp_q[0].data));
      end
      if (fin[0]) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_done: port_id=0x%0h with nothing expected (cyc %0d)", port_id, cyc);
        end else begin
          e_mon = exp_q.pop_front();
          chk("port_id", int'(port_id), int'(e_mon.addr));
          chk("out_port", int'(out_port), int'(e_mon.data));
          chk("done_cycle", cyc, e_mon.cyc);
          chk("addr_phase_len", a_low, 3 * PHASE);
          chk("addr_strobe_len", wr_a, PHASE);
          chk("data_strobe_len", strobe_d, PHASE);
          popped++;
        end
        a_low = 0; wr_a = 0; strobe_d = 0;
      end
    end
  end

  // Stimulus: power-up reset, long free run, then random mid-read resets.
  initial begin
    int  k, seen, guard, skip;
    bit  hit, rd_prev;
    reset    = 1'b0;
    probe_en = 1'b0;
    addr_lat = 8'h00;
    for (int a = 0; a < 256; a++) rtc_mem[a] = 8'($urandom);
    rtc_mem[8'h21] = 8'h45; rtc_mem[8'h22] = 8'h30; rtc_mem[8'h23] = 8'h12;
    rtc_mem[8'h24] = 8'h24; rtc_mem[8'h25] = 8'h05; rtc_mem[8'h26] = 8'h16;
    build_expect();
    @(negedge clk); probe_check();
    @(negedge clk); #2 reset = 1'b1;
    repeat (1200) @(negedge clk);
    #1 count_check("epoch0_done_count");

    for (int ep = 1; ep <= 3; ep++) begin
      k = $urandom_range(0, 7);
      seen = 0; guard = 0; hit = 1'b0; rd_prev = reg_rd;
      while (!hit && guard < 2000) begin
        @(negedge clk);
        guard++;
        if (rd_prev && !reg_rd) begin
          if (seen == k) hit = 1'b1;
          seen++;
        end
        rd_prev = reg_rd;
      end
      if (!hit) begin
        checks++; failures++;
        $display("FAIL rd_wait_timeout: no read strobe within %0d cycles", guard);
      end else begin
        skip = $urandom_range(0, 8);
        repeat (skip) @(negedge clk);
        #1 count_check("pre_reset_done_count");
        chk("rd_low_at_reset", int'(reg_rd), 0);
      end
      #1 reset = 1'b0;
      #1;
      chk("async_rst_strobes", int'({reg_a_d, reg_cs, reg_rd, reg_wr}), 4'hF);
      chk("async_rst_fin", int'(fin), 0);
      for (int a = 8'h21; a <= 8'h26; a++) rtc_mem[a] = 8'($urandom);
      build_expect();
      popped = 0;
      @(negedge clk); probe_check();
      @(negedge clk); #2 reset = 1'b1;
      repeat ($urandom_range(600, 1000)) @(negedge clk);
      #1 count_check("epoch_done_count");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
